touch_poll_sequencer: RTL
=========================

TOUCH_POLL_SEQUENCER -- requirements
Module: touch_poll_sequencer

Interface
REQ-001 SHALL have parameter POLL_TICKS, default 100000, meaning clk cycles between poll starts.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 4096, meaning max clk cycles waiting for one SPI result.
REQ-003 SHALL have parameter CMD_X, default 8'hD0, meaning X-channel command byte.
REQ-004 SHALL have parameter CMD_Y, default 8'h90, meaning Y-channel command byte.
REQ-005 SHALL have parameter EDGE_MIN, default 12'd64, meaning minimum valid raw coordinate; maximum valid raw coordinate is 4095-EDGE_MIN.
REQ-006 SHALL have ports:
 clk  in  1  clock; single clock domain.
 rst  in  1  reset; synchronous, active-high.
 ena  in  1  polling enable.
 spi_mode  out  spi_transaction_t  transaction type for the SPI controller.
 spi_i_data  out  16  command word for the SPI controller.
 spi_i_ready  in  1  SPI controller ready for a new transaction.
 spi_o_valid  in  1  SPI controller result valid.
 spi_o_data  in  24  SPI controller result.
 x  out  12  last accepted X.
 y  out  12  last accepted Y.
 touched  out  1  last completed pair was in range.
 sample_valid  out  1  one-cycle pulse per completed pair.
 busy  out  1  a poll is in progress.
 err  out  1  sticky SPI timeout.

Function
REQ-007 SHALL implement states S_IDLE, S_ISSUE_X, S_WAIT_X, S_ISSUE_Y, S_WAIT_Y, S_PUBLISH, S_ERROR.
REQ-008 SHALL count poll_ctr up by one each cycle in S_IDLE while ena=1, and hold it at 0 while ena=0.
REQ-009 SHALL, in S_IDLE, move to S_ISSUE_X when poll_ctr = POLL_TICKS-1, clearing poll_ctr.
REQ-010 SHALL drive spi_mode = WRITE_8_READ_16 at all times.
REQ-011 SHALL drive spi_i_data to 16'h0000 in every state except the issue cycle; the SPI controller starts on any nonzero i_data.
REQ-012 SHALL, in S_ISSUE_X with spi_i_ready=1, drive spi_i_data = {CMD_X, 8'h00} for exactly one cycle, then move to S_WAIT_X.
REQ-013 SHALL, in S_ISSUE_X with spi_i_ready=0, hold in S_ISSUE_X with spi_i_data = 0.
REQ-014 SHALL make S_ISSUE_Y, S_WAIT_Y behave as S_ISSUE_X, S_WAIT_X but use CMD_Y.
REQ-015 SHALL, in a wait state when spi_o_valid=1, capture raw = spi_o_data[14:3] (12 bits) into the X or Y holding register and advance to the next state (S_WAIT_X to S_ISSUE_Y, S_WAIT_Y to S_PUBLISH).
REQ-016 SHALL clear wait_ctr on entry to each wait state and increment it by one each cycle in that state.
REQ-017 SHALL, in a wait state, go to S_ERROR and set err=1 when wait_ctr reaches TIMEOUT_TICKS-1 with spi_o_valid=0.
REQ-018 SHALL give spi_o_valid priority over timeout when both occur in the same cycle.
REQ-019 SHALL, in S_PUBLISH, compute in_range = both raw values within [EDGE_MIN, 4095-EDGE_MIN] inclusive.
REQ-020 SHALL, in S_PUBLISH, set touched <= in_range and pulse sample_valid for one cycle.
REQ-021 SHALL, in S_PUBLISH, load x and y from the holding registers only when in_range=1, and otherwise hold x and y.
REQ-022 SHALL return from S_PUBLISH to S_IDLE.
REQ-023 SHALL drive busy = 1 in every state except S_IDLE and S_ERROR.
REQ-024 SHALL make ena deassertion mid-poll take effect only at S_IDLE; an in-flight poll completes.
REQ-025 SHALL hold S_ERROR while ena=1 and move to S_IDLE when ena=0.
REQ-026 SHALL keep err set until rst; it is not cleared by leaving S_ERROR.
REQ-027 SHALL ignore spi_o_valid outside wait states.

Reset
REQ-028 SHALL, while rst=1 is sampled, force state=S_IDLE, clear poll_ctr, wait_ctr and both holding registers, and drive x=0, y=0, touched=0, sample_valid=0, busy=0, err=0, spi_i_data=0.
REQ-029 SHALL abandon any in-flight poll when rst is asserted mid-operation, with no sample_valid pulse.

Verification
REQ-030 Bench SHALL cover the nominal poll: POLL_TICKS=10, ena=1, spi_i_ready=1, model returns X data 24'h004000 and Y data 24'h002000 -> spi_i_data D000 then 9000 each for one cycle, x=12'h800, y=12'h400, touched=1, one sample_valid pulse.
REQ-031 Bench SHALL cover out of range: X data 24'h000000 -> touched=0, x and y unchanged, sample_valid still pulses.
REQ-032 Bench SHALL cover the ready stall: spi_i_ready=0 for 20 cycles in S_ISSUE_X -> spi_i_data stays 0 and the command is issued on the first ready cycle.
REQ-033 Bench SHALL cover timeout: no spi_o_valid, TIMEOUT_TICKS=16 -> err=1 and busy=0 16 cycles after entering S_WAIT_X; after ena=0 the block returns to S_IDLE with err still 1.
REQ-034 Bench SHALL cover the simultaneous event: spi_o_valid on the timeout cycle -> the sample is captured and err stays 0.
REQ-035 Bench SHALL cover reset in S_WAIT_Y: rst pulse -> all outputs at reset values, no sample_valid, and the next poll starts after POLL_TICKS.

Source files
------------

// File: rtl/touch_poll_sequencer.sv
// Periodic touch-panel poller: issues an X then a Y conversion command to an SPI
// controller, range-checks both results and publishes the accepted coordinate pair.
package touch_poll_pkg;
  typedef enum logic [1:0] {
    WRITE_8         = 2'd0,
    WRITE_16        = 2'd1,
    WRITE_8_READ_8  = 2'd2,
    WRITE_8_READ_16 = 2'd3
  } spi_transaction_t;
endpackage

module touch_poll_sequencer
  import touch_poll_pkg::*;
#(
  parameter int          POLL_TICKS    = 100000,
  parameter int          TIMEOUT_TICKS = 4096,
  parameter logic [7:0]  CMD_X         = 8'hD0,
  parameter logic [7:0]  CMD_Y         = 8'h90,
  parameter logic [11:0] EDGE_MIN      = 12'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output spi_transaction_t spi_mode,
  output logic [15:0]      spi_i_data,
  input  logic             spi_i_ready,
  input  logic             spi_o_valid,
  input  logic [23:0]      spi_o_data,
  output logic [11:0]      x,
  output logic [11:0]      y,
  output logic             touched,
  output logic             sample_valid,
  output logic             busy,
  output logic             err
);

  localparam int POLL_W = $clog2(POLL_TICKS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TICKS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_TICKS - 1);
  localparam logic [11:0]       EDGE_MAX  = 12'd4095 - EDGE_MIN;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_X, S_WAIT_X, S_ISSUE_Y, S_WAIT_Y, S_PUBLISH, S_ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [POLL_W-1:0]   poll_ctr_reg, poll_ctr_next;
  logic [WAIT_W-1:0]   wait_ctr_reg, wait_ctr_next;
  logic [11:0]         raw_reg [2];
  logic [11:0]         x_reg, y_reg;
  logic                touched_reg, sample_valid_reg, err_reg;
  logic                capture_x, capture_y, publish, set_err;
  logic [1:0]          ch_ok;
  logic                in_range;
  logic                unused_spi_bits;

  // Only the 12-bit conversion result in [14:3] carries information.
  assign unused_spi_bits = ^{spi_o_data[23:15], spi_o_data[2:0]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_range
    assign ch_ok[gi] = (raw_reg[gi] >= EDGE_MIN) && (raw_reg[gi] <= EDGE_MAX);
  end
  assign in_range = &ch_ok;

  always_comb begin
    state_next    = state_reg;
    poll_ctr_next = '0;
    wait_ctr_next = '0;
    spi_i_data    = 16'h0000;
    capture_x     = 1'b0;
    capture_y     = 1'b0;
    publish       = 1'b0;
    set_err       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ena) begin
          if (poll_ctr_reg == POLL_LAST) state_next = S_ISSUE_X;
          else poll_ctr_next = poll_ctr_reg + POLL_W'(1);
        end
      end
      S_ISSUE_X: begin
        if (spi_i_ready) begin
          spi_i_data = {CMD_X, 8'h00};
          state_next = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        wait_ctr_next = wait_ctr_reg + WAIT_W'(1);
        if (spi_o_valid) begin
          capture_x  = 1'b1;
          state_next = S_ISSUE_Y;
        end else if (wait_ctr_reg == WAIT_LAST) begin
          set_err    = 1'b1;
          state_next = S_ERROR;
        end
      end
      S_ISSUE_Y: begin
        if (spi_i_ready) begin
          spi_i_data = {CMD_Y, 8'h00};
          state_next = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        wait_ctr_next = wait_ctr_reg + WAIT_W'(1);
        if (spi_o_valid) begin
          capture_y  = 1'b1;
          state_next = S_PUBLISH;
        end else if (wait_ctr_reg == WAIT_LAST) begin
          set_err    = 1'b1;
          state_next = S_ERROR;
        end
      end
      S_PUBLISH: begin
        publish    = 1'b1;
        state_next = S_IDLE;
      end
      S_ERROR: begin
        if (!ena) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      poll_ctr_reg     <= '0;
      wait_ctr_reg     <= '0;
      raw_reg[0]       <= '0;
      raw_reg[1]       <= '0;
      x_reg            <= '0;
      y_reg            <= '0;
      touched_reg      <= 1'b0;
      sample_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      poll_ctr_reg     <= poll_ctr_next;
      wait_ctr_reg     <= wait_ctr_next;
      sample_valid_reg <= publish;
      if (capture_x) raw_reg[0] <= spi_o_data[14:3];
      if (capture_y) raw_reg[1] <= spi_o_data[14:3];
      if (publish) touched_reg <= in_range;
      // Out-of-range pairs still report touched=0 but keep the last good position.
      if (publish && in_range) begin
        x_reg <= raw_reg[0];
        y_reg <= raw_reg[1];
      end
      if (set_err) err_reg <= 1'b1;
    end
  end

  assign spi_mode     = WRITE_8_READ_16;
  assign x            = x_reg;
  assign y            = y_reg;
  assign touched      = touched_reg;
  assign sample_valid = sample_valid_reg;
  assign err          = err_reg;
  assign busy         = (state_reg != S_IDLE) && (state_reg != S_ERROR);

endmodule
